// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube frame receiver and scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package led_cube_pkg;

  // Receiver states: wait for sync, collect data bytes, hold a full frame until the scan wraps.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes needed to carry one bit per voxel, LSB first.
  function automatic int frame_bytes(input int n);
    return (n * n * n + 7) / 8;
  endfunction

endpackage

// File: rtl/led_cube_frame_rx.sv
// Frame receiver: sync byte, then one data byte per 8 voxels into a back buffer.
// Latency: last data byte accepted at t puts the frame in PEND at t+1.
// Backpressure: s_ready_o low only while a complete frame waits for swap_ack_i.
module led_cube_frame_rx
  import led_cube_pkg::*;
#(
  parameter int CUBE_N         = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int FRAME_BYTES   = frame_bytes(CUBE_N)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     swap_ack_i,
  output logic                     frame_ready_o,
  output logic                     rx_err_o,
  output logic [8*FRAME_BYTES-1:0] back_o
);

  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [8*FRAME_BYTES-1:0] back_q, back_d;
  logic                     ready_q, ready_d;
  logic                     err_q, err_d;
  logic                     accept;

  assign accept        = s_valid_i && ready_q;
  assign s_ready_o     = ready_q;
  assign frame_ready_o = (state_q == PEND);
  assign rx_err_o      = err_q;
  assign back_o        = back_q;

  // Next-state logic: byte collection, inter-byte timeout, and release on swap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    back_d  = back_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (accept && (s_data_i == SYNC_BYTE)) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          // 0xA5 here is ordinary voxel data; only IDLE treats it as sync.
          back_d[8*int'(idx_q) +: 8] = s_data_i;
          gap_d = '0;
          if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            state_d = PEND;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          // Stalled sender: abandon the partial frame, front buffer is untouched.
          state_d = IDLE;
          gap_d   = '0;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      PEND: begin
        if (swap_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered ready follows the state we are about to enter.
    ready_d = (state_d != PEND);
  end

  // State register; reset discards any partial frame and holds s_ready low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      back_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      back_q  <= back_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/led_cube_frame_scanner.sv
// Cube scanner: double-buffered voxel frame, layer multiplexing with blanking and PWM brightness.
// Latency: col/layer one cycle behind the scan counters; frame swap at the next full-scan wrap.
// Backpressure: s_ready drops while a received frame waits for the wrap, else always ready.
module led_cube_frame_scanner
  import led_cube_pkg::*;
#(
  parameter int CUBE_N         = 4,
  parameter int LAYER_CYCLES   = 1024,
  parameter int BLANK_CYCLES   = 32,
  parameter int PWM_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PWM_BITS-1:0]        brightness,
  output logic [CUBE_N*CUBE_N-1:0]   col,
  output logic [CUBE_N-1:0]          layer,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  output logic                       rx_err
);

  localparam int COLS        = CUBE_N * CUBE_N;
  localparam int VOXELS      = COLS * CUBE_N;
  localparam int FRAME_BYTES = frame_bytes(CUBE_N);
  localparam int SLOT_W      = (LAYER_CYCLES > 1) ? $clog2(LAYER_CYCLES) : 1;
  localparam int Z_W         = (CUBE_N > 1) ? $clog2(CUBE_N) : 1;

  logic [8*FRAME_BYTES-1:0] back;
  logic                     frame_ready;
  logic                     swap;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [Z_W-1:0]      z_q, z_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [VOXELS-1:0]   front_q, front_d;
  logic [COLS-1:0]     col_q, col_d;
  logic [CUBE_N-1:0]   layer_q, layer_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                slot_wrap;
  logic                scan_wrap;
  logic                drive_on;

  led_cube_frame_rx #(
    .CUBE_N         (CUBE_N),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i         (clk_clk),
    .rst_ni        (reset_reset_n),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .swap_ack_i    (swap),
    .frame_ready_o (frame_ready),
    .rx_err_o      (rx_err),
    .back_o        (back)
  );

  // Scan counters: slot within a layer, layer index, free-running PWM phase.
  always_comb begin
    slot_wrap = (slot_q == SLOT_W'(LAYER_CYCLES - 1));
    scan_wrap = slot_wrap && (z_q == Z_W'(CUBE_N - 1));
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    z_d       = z_q;
    if (slot_wrap) begin
      z_d = (z_q == Z_W'(CUBE_N - 1)) ? '0 : z_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Buffer swap only at the end of the last layer slot, so a frame never tears mid-scan.
  always_comb begin
    swap          = scan_wrap && frame_ready;
    front_d       = front_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (swap) begin
      front_d       = back[VOXELS-1:0];
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Drive: dark during the blanking head of each slot and during the PWM off phase.
  always_comb begin
    drive_on = (slot_q >= SLOT_W'(BLANK_CYCLES)) && (pwm_q < brightness);
    col_d    = '0;
    layer_d  = '0;
    if (drive_on) begin
      layer_d[z_q] = 1'b1;
      col_d        = front_q[int'(z_q)*COLS +: COLS];
    end
  end

  // Scanner, front buffer and output registers; reset blanks the display.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      slot_q        <= '0;
      z_q           <= '0;
      pwm_q         <= '0;
      front_q       <= '0;
      col_q         <= '0;
      layer_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      z_q           <= z_d;
      pwm_q         <= pwm_d;
      front_q       <= front_d;
      col_q         <= col_d;
      layer_q       <= layer_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign col         = col_q;
  assign layer       = layer_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
